// File: rtl/i_raster_pkg.sv
// Shared definitions for the raster index generator: FSM states and default widths.
package i_raster_pkg;

   localparam int DEF_COL_BITS = 13;
   localparam int DEF_ROW_BITS = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/i_wrap_counter.sv
// Up-counter that returns to zero after reaching wrap_val; at_wrap flags the terminal value.
module i_wrap_counter #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] wrap_val,
   output logic [WIDTH-1:0] count,
   output logic             at_wrap
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign at_wrap = (count_q == wrap_val);
   assign count   = count_q;

   // wrap_val never exceeds 2^WIDTH-2, so the increment cannot overflow.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = at_wrap ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/i_raster_counter.sv
// Frame scanner: walks (col,row) in raster order under ready/valid handshake,
// with frame markers, a done pulse and rejection of zero-sized frames.
module i_raster_counter
   import i_raster_pkg::*;
#(
   parameter int COL_BITS = DEF_COL_BITS,
   parameter int ROW_BITS = DEF_ROW_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                start,
   input  logic [COL_BITS-1:0] num_cols,
   input  logic [ROW_BITS-1:0] num_rows,
   input  logic                ready,
   output logic                valid,
   output logic [COL_BITS-1:0] col,
   output logic [ROW_BITS-1:0] row,
   output logic                sof,
   output logic                eof,
   output logic                sol,
   output logic                eol,
   output logic                busy,
   output logic                done,
   output logic                dim_err
);

   state_e              state_q, state_d;
   logic [COL_BITS-1:0] cols_m1_q, cols_m1_d;
   logic [ROW_BITS-1:0] rows_m1_q, rows_m1_d;
   logic                dim_err_q, dim_err_d;

   logic                dims_ok;
   logic                start_ok;
   logic                cnt_clear;
   logic                accept;
   logic                col_at_wrap;
   logic                row_at_wrap;
   logic [COL_BITS-1:0] col_cnt;
   logic [ROW_BITS-1:0] row_cnt;

   assign dims_ok   = (num_cols != '0) && (num_rows != '0);
   assign start_ok  = (state_q == ST_IDLE) && start && dims_ok && !clear;
   assign cnt_clear = clear || start_ok;
   assign accept    = valid && ready;

   i_wrap_counter #(.WIDTH(COL_BITS)) u_col_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .enable   (accept),
      .wrap_val (cols_m1_q),
      .count    (col_cnt),
      .at_wrap  (col_at_wrap)
   );

   // Rows advance only when the column counter wraps on an accepted pixel.
   i_wrap_counter #(.WIDTH(ROW_BITS)) u_row_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .enable   (col_at_wrap && accept),
      .wrap_val (rows_m1_q),
      .count    (row_cnt),
      .at_wrap  (row_at_wrap)
   );

   always_comb begin
      state_d   = state_q;
      cols_m1_d = cols_m1_q;
      rows_m1_d = rows_m1_q;
      dim_err_d = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (dims_ok) begin
                     state_d   = ST_RUN;
                     cols_m1_d = num_cols - COL_BITS'(1);
                     rows_m1_d = num_rows - ROW_BITS'(1);
                  end else begin
                     dim_err_d = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (ready && col_at_wrap && row_at_wrap) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cols_m1_q <= '0;
         rows_m1_q <= '0;
         dim_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cols_m1_q <= cols_m1_d;
         rows_m1_q <= rows_m1_d;
         dim_err_q <= dim_err_d;
      end
   end

   assign valid   = (state_q == ST_RUN);
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign dim_err = dim_err_q;
   assign col     = col_cnt;
   assign row     = row_cnt;
   assign sol     = valid && (col_cnt == '0);
   assign eol     = valid && col_at_wrap;
   assign sof     = sol && (row_cnt == '0);
   assign eof     = eol && row_at_wrap;

endmodule

// File: tb/tb_i_raster_counter.sv
// Randomised and directed checks of i_raster_counter against a pixel-queue reference model.
module tb_i_raster_counter;

   localparam int CB = 4;
   localparam int RB = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          start;
   logic [CB-1:0] num_cols;
   logic [RB-1:0] num_rows;
   logic          ready;
   logic          valid;
   logic [CB-1:0] col;
   logic [RB-1:0] row;
   logic          sof, eof, sol, eol;
   logic          busy, done, dim_err;

   always #5 clk = ~clk;

   i_raster_counter #(.COL_BITS(CB), .ROW_BITS(RB)) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .start    (start),
      .num_cols (num_cols),
      .num_rows (num_rows),
      .ready    (ready),
      .valid    (valid),
      .col      (col),
      .row      (row),
      .sof      (sof),
      .eof      (eof),
      .sol      (sol),
      .eol      (eol),
      .busy     (busy),
      .done     (done),
      .dim_err  (dim_err)
   );

   typedef struct {
      int c;
      int r;
      bit sol;
      bit eol;
      bit sof;
      bit eof;
   } pix_t;

   pix_t pix_q[$];
   bit   done_exp = 1'b0;
   bit   err_exp  = 1'b0;
   int   n_cmp    = 0;
   int   n_bad    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected scan: every pixel of the frame in raster order, markers from the frame geometry.
   task automatic fill(input int nc, input int nr);
      pix_t p;
      for (int r = 0; r < nr; r++) begin
         for (int c = 0; c < nc; c++) begin
            p.c   = c;
            p.r   = r;
            p.sol = (c == 0);
            p.eol = (c == nc - 1);
            p.sof = (c == 0) && (r == 0);
            p.eof = (c == nc - 1) && (r == nr - 1);
            pix_q.push_back(p);
         end
      end
   endtask

   task automatic model_edge(input bit st, input int nc, input int nr, input bit rdy, input bit clr);
      bit running;
      bit in_done;
      running = (pix_q.size() != 0);
      in_done = done_exp;
      done_exp = 1'b0;
      err_exp  = 1'b0;
      if (clr) begin
         pix_q.delete();
      end else if (running) begin
         if (rdy) begin
            void'(pix_q.pop_front());
            if (pix_q.size() == 0) done_exp = 1'b1;
         end
      end else if (!in_done && st) begin
         if (nc == 0 || nr == 0) err_exp = 1'b1;
         else fill(nc, nr);
      end
   endtask

   task automatic check_outputs(input string tag);
      pix_t p;
      bit   v;
      int   ec, er;
      logic [3:0] ef;
      v  = (pix_q.size() != 0);
      ec = 0;
      er = 0;
      ef = 4'b0000;
      if (v) begin
         p  = pix_q[0];
         ec = p.c;
         er = p.r;
         ef = {p.sof, p.eof, p.sol, p.eol};
      end
      chk({tag, ".valid"}, 32'(valid), 32'(v));
      chk({tag, ".col"}, 32'(col), 32'(ec));
      chk({tag, ".row"}, 32'(row), 32'(er));
      chk({tag, ".flags"}, 32'({sof, eof, sol, eol}), 32'(ef));
      chk({tag, ".busy"}, 32'(busy), 32'(v || done_exp));
      chk({tag, ".done"}, 32'(done), 32'(done_exp));
      chk({tag, ".dim_err"}, 32'(dim_err), 32'(err_exp));
   endtask

   task automatic step(input bit st, input int nc, input int nr, input bit rdy, input bit clr,
                       input string tag);
      start    = st;
      num_cols = CB'(nc);
      num_rows = RB'(nr);
      ready    = rdy;
      clear    = clr;
      @(posedge clk);
      #1;
      model_edge(st, nc, nr, rdy, clr);
      check_outputs(tag);
   endtask

   // mode 0: ready always high; 1: ready alternates starting high; 2: random ready and stray starts.
   task automatic run_frame(input int nc, input int nr, input int mode, input string tag);
      int k;
      int accepts;
      bit rdy;
      k = 0;
      accepts = 0;
      step(1'b1, nc, nr, 1'b1, 1'b0, tag);
      while ((pix_q.size() != 0 || done_exp) && k < 2000) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (k % 2 == 0);
            default: rdy = ($urandom % 3 != 0);
         endcase
         if (pix_q.size() != 0 && rdy) accepts++;
         step((mode == 2) ? ($urandom % 4 == 0) : 1'b0,
              $urandom_range(0, 15), $urandom_range(0, 31), rdy, 1'b0, tag);
         k++;
      end
      chk({tag, ".terminated"}, 32'(k < 2000), 32'd1);
      if (nc != 0 && nr != 0) chk({tag, ".accepts"}, 32'(accepts), 32'(nc * nr));
      $display("frame %s %0dx%0d mode %0d: %0d cycles, %0d accepts", tag, nc, nr, mode, k, accepts);
   endtask

   initial begin
      rst      = 1'b1;
      clear    = 1'b0;
      start    = 1'b0;
      ready    = 1'b0;
      num_cols = '0;
      num_rows = '0;
      #2;
      check_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 3, 2, 1'b1, 1'b0, "idle");

      run_frame(3, 2, 0, "f3x2_full");
      run_frame(3, 2, 1, "f3x2_toggle");
      run_frame(1, 1, 0, "f1x1");
      run_frame(1, 4, 1, "f1x4");
      run_frame(5, 1, 0, "f5x1");

      step(1'b1, 0, 5, 1'b1, 1'b0, "dim0x5");
      step(1'b0, 0, 5, 1'b1, 1'b0, "dim0x5_after");
      step(1'b1, 5, 0, 1'b1, 1'b0, "dim5x0");
      step(1'b0, 5, 0, 1'b1, 1'b0, "dim5x0_after");
      $display("dim_err transactions issued");

      // Clear at pixel (2,1) of a 4x4 frame, then a clean 2x2 frame.
      step(1'b1, 4, 4, 1'b1, 1'b0, "clr_start");
      for (int i = 0; i < 50 && pix_q.size() != 0 && !(pix_q[0].c == 2 && pix_q[0].r == 1); i++)
         step(1'b0, 4, 4, 1'b1, 1'b0, "clr_run");
      step(1'b1, 4, 4, 1'b1, 1'b1, "clr_hit");
      step(1'b0, 4, 4, 1'b1, 1'b0, "clr_after");
      step(1'b1, 3, 3, 1'b1, 1'b1, "clr_vs_start");
      run_frame(2, 2, 0, "f2x2_after_clear");

      run_frame(15, 1, 0, "f15x1_max_cols");
      run_frame(15, 31, 2, "f15x31_max");

      // Asynchronous reset between clock edges in the middle of a frame.
      step(1'b1, 4, 3, 1'b1, 1'b0, "rst_start");
      step(1'b0, 4, 3, 1'b1, 1'b0, "rst_run");
      step(1'b0, 4, 3, 1'b1, 1'b0, "rst_run");
      #3;
      rst = 1'b1;
      #1;
      pix_q.delete();
      done_exp = 1'b0;
      err_exp  = 1'b0;
      check_outputs("rst_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 4, 3, 1'b1, 1'b0, "rst_idle");
      step(1'b0, 4, 3, 1'b1, 1'b0, "rst_idle");
      run_frame(4, 3, 1, "f4x3_after_rst");

      for (int f = 0; f < 25; f++)
         run_frame($urandom_range(0, 6), $urandom_range(0, 5), 2, "rand_frame");

      for (int i = 0; i < 600; i++)
         step($urandom % 3 == 0, $urandom_range(0, 5), $urandom_range(0, 4),
              $urandom % 4 != 0, $urandom % 40 == 0, "rand_step");
      $display("random step phase complete");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
